// File: rtl/ddr2_pkg.sv
// ddr2_pkg: shared command encoding, queue entry layout and burst helper for the ddr2 host front end.
package ddr2_pkg;
    localparam int ADDR_W = 25;
    localparam int DATA_W = 16;
    typedef enum logic [2:0] {NOP, SCR, SCW, BLR, BLW, ATR, ATW, NOP7} cmd_e;
    typedef struct packed {
        cmd_e              cmd;
        logic [1:0]        sz;
        logic [2:0]        op;
        logic [ADDR_W-1:0] addr;
    } cmd_entry_t;
    typedef enum logic {IDLE, BLKWR} state_e;
    function automatic logic [5:0] burst_len(input logic [1:0] sz);
        return {1'b0, sz, 3'b000} + 6'd8;
    endfunction
endpackage

// File: rtl/ddr2_host_if_if.sv
// ddr2_host_if_if: host port plus engine-side queue taps of the ddr2 host front end.
interface ddr2_host_if_if;
    import ddr2_pkg::*;
    cmd_e              cmd;
    logic [1:0]        sz;
    logic [2:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic              fetching;
    logic              notfull;
    logic [6:0]        fillcount;
    logic [DATA_W-1:0] dout;
    logic [ADDR_W-1:0] raddr;
    logic              validout;
    logic              cq_valid;
    cmd_entry_t        cq_entry;
    logic              cq_pop;
    logic              wq_valid;
    logic [DATA_W-1:0] wq_data;
    logic              wq_pop;
    logic              rq_push;
    logic [DATA_W-1:0] rq_data;
    logic [ADDR_W-1:0] rq_addr;
    logic              rq_ready;
    logic [1:0]        err;
    modport slave (
        input  cmd, sz, op, addr, din, fetching, cq_pop, wq_pop, rq_push, rq_data, rq_addr,
        output notfull, fillcount, dout, raddr, validout, cq_valid, cq_entry, wq_valid, wq_data, rq_ready, err
    );
    modport master (
        output cmd, sz, op, addr, din, fetching, cq_pop, wq_pop, rq_push, rq_data, rq_addr,
        input  notfull, fillcount, dout, raddr, validout, cq_valid, cq_entry, wq_valid, wq_data, rq_ready, err
    );
endinterface

// File: rtl/ddr2_sync_fifo.sv
// ddr2_sync_fifo: single-clock FIFO with registered count; push when full and pop when empty are ignored.
module ddr2_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
            count  <= (do_push && !do_pop) ? count + 1'b1 : (do_pop && !do_push) ? count - 1'b1 : count;
        end
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/ddr2_host_if.sv
// ddr2_host_if: host command/write-data capture and read-return delivery for ddr2_controller.
// Define HOSTIF_ERR_EN to build the sticky protocol-error flags on err.
module ddr2_host_if
    import ddr2_pkg::*;
#(
    parameter int CMD_DEPTH  = 16,
    parameter int DATA_DEPTH = 64,
    parameter int RET_DEPTH  = 32
) (
    input logic           clk,
    input logic           rst_n,
    ddr2_host_if_if.slave bus
);
    localparam int RW = ADDR_W + DATA_W;
    state_e                       state, state_n;
    logic [5:0]                   cnt, cnt_n;
    logic                         cq_push, wq_push, rq_pop;
    logic                         cq_full, cq_empty, wq_full, wq_empty, rq_full, rq_empty;
    logic                         needs_data, takes;
    logic [$clog2(CMD_DEPTH):0]   cq_count;
    logic [$clog2(DATA_DEPTH):0]  wq_count;
    logic [$clog2(RET_DEPTH):0]   rq_count;
    logic [RW-1:0]                rq_head;
    ddr2_sync_fifo #(.WIDTH($bits(cmd_entry_t)), .DEPTH(CMD_DEPTH)) u_cq (
        .clk(clk), .rst_n(rst_n), .push(cq_push), .pop(bus.cq_pop),
        .wdata({bus.cmd, bus.sz, bus.op, bus.addr}), .rdata(bus.cq_entry),
        .count(cq_count), .full(cq_full), .empty(cq_empty)
    );
    ddr2_sync_fifo #(.WIDTH(DATA_W), .DEPTH(DATA_DEPTH)) u_wq (
        .clk(clk), .rst_n(rst_n), .push(wq_push), .pop(bus.wq_pop),
        .wdata(bus.din), .rdata(bus.wq_data),
        .count(wq_count), .full(wq_full), .empty(wq_empty)
    );
    ddr2_sync_fifo #(.WIDTH(RW), .DEPTH(RET_DEPTH)) u_rq (
        .clk(clk), .rst_n(rst_n), .push(bus.rq_push), .pop(rq_pop),
        .wdata({bus.rq_addr, bus.rq_data}), .rdata(rq_head),
        .count(rq_count), .full(rq_full), .empty(rq_empty)
    );
    assign bus.notfull   = !cq_full;
    assign bus.fillcount = 7'(wq_count);
    assign bus.cq_valid  = !cq_empty;
    assign bus.wq_valid  = !wq_empty;
    assign bus.rq_ready  = !rq_full;
    assign rq_pop        = bus.fetching && !rq_empty;
    assign needs_data    = bus.cmd inside {SCW, ATR, ATW, BLW};
    assign takes         = needs_data || bus.cmd inside {SCR, BLR};
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    // In a burst the counter holds the words still owed after the one taken with the command.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cq_push = 1'b0;
        wq_push = 1'b0;
        if (state == IDLE) begin
            if (takes && !cq_full && (!needs_data || !wq_full)) begin
                cq_push = 1'b1;
                wq_push = needs_data;
                state_n = bus.cmd == BLW ? BLKWR : IDLE;
                cnt_n   = bus.cmd == BLW ? burst_len(bus.sz) - 6'd1 : cnt;
            end
        end else if (!wq_full) begin
            wq_push = 1'b1;
            cnt_n   = cnt - 6'd1;
            state_n = cnt == 6'd1 ? IDLE : BLKWR;
        end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            bus.validout <= 1'b0;
            bus.dout     <= '0;
            bus.raddr    <= '0;
        end else begin
            bus.validout <= rq_pop;
            if (rq_pop) {bus.raddr, bus.dout} <= rq_head;
        end
`ifdef HOSTIF_ERR_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) bus.err <= 2'b00;
        else begin
            bus.err[0] <= bus.err[0] || (bus.rq_push && rq_full);
            bus.err[1] <= bus.err[1] || (bus.cq_pop && cq_empty) || (bus.wq_pop && wq_empty);
        end
`else
    assign bus.err = 2'b00;
`endif
endmodule

// File: tb/tb_ddr2_host_if.sv
// tb_ddr2_host_if: directed vectors with hand-computed expectations for ddr2_host_if.
module tb_ddr2_host_if;
    import ddr2_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;
    ddr2_host_if_if bus();
    ddr2_host_if dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        cmd_e exp_cmds [4];
        int   n;
        exp_cmds = '{BLW, BLW, SCR, SCW};
        bus.cmd = NOP; bus.sz = 0; bus.op = 0; bus.addr = 0; bus.din = 0; bus.fetching = 0;
        bus.cq_pop = 0; bus.wq_pop = 0; bus.rq_push = 0; bus.rq_data = 0; bus.rq_addr = 0;
        repeat (2) tick();
        check("rst_notfull", 64'(bus.notfull), 1);
        check("rst_fill", 64'(bus.fillcount), 0);
        check("rst_validout", 64'(bus.validout), 0);
        check("rst_dout", 64'(bus.dout), 0);
        check("rst_raddr", 64'(bus.raddr), 0);
        check("rst_cq_valid", 64'(bus.cq_valid), 0);
        check("rst_wq_valid", 64'(bus.wq_valid), 0);
        check("rst_rq_ready", 64'(bus.rq_ready), 1);
        check("rst_err", 64'(bus.err), 0);
        rst_n = 1'b1;
        tick();

        // single write
        bus.cmd = SCW; bus.addr = 25'h008F07A; bus.din = 16'hFACE; bus.op = 3'd5;
        tick();
        bus.cmd = NOP;
        check("scw_cq_valid", 64'(bus.cq_valid), 1);
        check("scw_cmd", 64'(bus.cq_entry.cmd), 2);
        check("scw_addr", 64'(bus.cq_entry.addr), 64'h008F07A);
        check("scw_op", 64'(bus.cq_entry.op), 5);
        check("scw_fill", 64'(bus.fillcount), 1);
        check("scw_wq_data", 64'(bus.wq_data), 64'hFACE);
        bus.cq_pop = 1; bus.wq_pop = 1;
        tick();
        bus.cq_pop = 0; bus.wq_pop = 0;
        check("scw_drained_cq", 64'(bus.cq_valid), 0);
        check("scw_drained_fill", 64'(bus.fillcount), 0);

        // 16-word burst; SCW on cmd during the burst must not be queued
        bus.cmd = BLW; bus.sz = 2'd1; bus.din = 16'd0;
        tick();
        bus.cmd = SCW;
        for (int i = 1; i < 16; i++) begin
            bus.din = 16'(i);
            tick();
        end
        bus.cmd = NOP;
        tick();
        check("blw_fill", 64'(bus.fillcount), 16);
        check("blw_cmd", 64'(bus.cq_entry.cmd), 4);
        check("blw_sz", 64'(bus.cq_entry.sz), 1);
        bus.cq_pop = 1;
        tick();
        bus.cq_pop = 0;
        check("blw_single_entry", 64'(bus.cq_valid), 0);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("blw_word%0d", i), 64'(bus.wq_data), 64'(i));
            bus.wq_pop = 1;
            tick();
        end
        bus.wq_pop = 0;
        check("blw_drained", 64'(bus.fillcount), 0);

        // command queue full
        bus.cmd = SCR;
        for (int i = 0; i < 16; i++) tick();
        check("cq_full_notfull", 64'(bus.notfull), 0);
        tick();
        bus.cmd = NOP;
        check("cq_17th_held", 64'(bus.notfull), 0);
        bus.cq_pop = 1;
        tick();
        bus.cq_pop = 0;
        check("cq_pop_notfull", 64'(bus.notfull), 1);
        n = 1;
        for (int i = 0; i < 40 && bus.cq_valid; i++) begin
            bus.cq_pop = 1;
            tick();
            n++;
        end
        bus.cq_pop = 0;
        check("cq_entries", 64'(n), 16);

        // write-data queue full
        repeat (2) begin
            bus.cmd = BLW; bus.sz = 2'd3; bus.din = 16'h1000;
            tick();
            bus.cmd = NOP;
            for (int i = 1; i < 32; i++) begin
                bus.din = 16'(16'h1000 + i);
                tick();
            end
        end
        check("wq_full_fill", 64'(bus.fillcount), 64);
        bus.cmd = SCR;
        tick();
        bus.cmd = SCW; bus.din = 16'hBEEF;
        repeat (2) tick();
        check("wq_scw_held", 64'(bus.fillcount), 64);
        bus.wq_pop = 1;
        tick();
        bus.wq_pop = 0;
        check("wq_pop_fill", 64'(bus.fillcount), 63);
        tick();
        bus.cmd = NOP;
        check("wq_scw_taken", 64'(bus.fillcount), 64);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wq_cq_valid%0d", i), 64'(bus.cq_valid), 1);
            check($sformatf("wq_cq_cmd%0d", i), 64'(bus.cq_entry.cmd), 64'(exp_cmds[i]));
            bus.cq_pop = 1;
            tick();
        end
        bus.cq_pop = 0;
        check("wq_cq_empty", 64'(bus.cq_valid), 0);
        bus.wq_pop = 1;
        repeat (63) tick();
        check("wq_last_word", 64'(bus.wq_data), 64'hBEEF);
        tick();
        bus.wq_pop = 0;
        check("wq_drained", 64'(bus.fillcount), 0);

        // return path
        for (int i = 0; i < 3; i++) begin
            bus.rq_push = 1; bus.rq_data = 16'(16'hA001 + i); bus.rq_addr = 25'(25'h100 + i);
            tick();
        end
        bus.rq_push = 0;
        check("rq_idle_validout", 64'(bus.validout), 0);
        bus.fetching = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rq_valid%0d", i), 64'(bus.validout), 1);
            check($sformatf("rq_dout%0d", i), 64'(bus.dout), 64'(16'hA001 + i));
            check($sformatf("rq_raddr%0d", i), 64'(bus.raddr), 64'(25'h100 + i));
        end
        tick();
        bus.fetching = 0;
        check("rq_done_validout", 64'(bus.validout), 0);
        check("rq_hold_dout", 64'(bus.dout), 64'hA003);

        // return queue overflow drops the 33rd word
        for (int i = 0; i < 33; i++) begin
            bus.rq_push = 1; bus.rq_data = 16'(16'h2000 + i); bus.rq_addr = 25'(i);
            tick();
            if (i == 31) check("rq_full_ready", 64'(bus.rq_ready), 0);
        end
        bus.rq_push = 0;
`ifdef HOSTIF_ERR_EN
        check("rq_ovf_err", 64'(bus.err), 1);
`else
        check("rq_ovf_err", 64'(bus.err), 0);
`endif
        bus.fetching = 1;
        repeat (32) tick();
        check("rq_ovf_last", 64'(bus.dout), 64'h201F);
        tick();
        bus.fetching = 0;
        check("rq_ovf_nomore", 64'(bus.validout), 0);

        // reset mid-burst
        bus.cmd = BLW; bus.sz = 2'd3; bus.din = 16'h55;
        tick();
        bus.cmd = NOP;
        repeat (4) tick();
        check("mid_burst_fill", 64'(bus.fillcount), 5);
        bus.rq_push = 1; bus.rq_data = 16'h77;
        tick();
        bus.rq_push = 0; bus.fetching = 1;
        tick();
        check("pre_rst_validout", 64'(bus.validout), 1);
        rst_n = 1'b0;
        #1;
        check("arst_fill", 64'(bus.fillcount), 0);
        check("arst_notfull", 64'(bus.notfull), 1);
        check("arst_validout", 64'(bus.validout), 0);
        check("arst_err", 64'(bus.err), 0);
        tick();
        rst_n = 1'b1; bus.fetching = 0;
        repeat (3) tick();
        check("post_rst_no_burst", 64'(bus.fillcount), 0);
        check("post_rst_cq", 64'(bus.cq_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
